// File: rtl/ariane_pkg.sv
// Shared return-address-stack definitions: default depth and the
// speculative checkpoint record captured on control-flow issue.
package ariane_pkg;

  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);

  // Snapshot used to repair the stack after a mispredict flush.
  typedef struct packed {
    logic [RAS_PTR_W-1:0] tos;
    logic [RAS_PTR_W:0]   cnt;
    logic [63:0]          top_value;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ctrl_stats.sv
// Four saturating 32-bit event counters for the return-address stack:
// accepted pushes, accepted pops, overflow events and underflow events.
module ras_ctrl_stats
  import ariane_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_evt_i,
  input  logic        pop_evt_i,
  input  logic        ovf_evt_i,
  input  logic        udf_evt_i,
  output logic [31:0] stat_push_o,
  output logic [31:0] stat_pop_o,
  output logic [31:0] stat_ovf_o,
  output logic [31:0] stat_udf_o
);

  logic [3:0]       evt;
  logic [3:0][31:0] cnt_q;
  logic [3:0][31:0] cnt_d;

  assign evt = {udf_evt_i, ovf_evt_i, pop_evt_i, push_evt_i};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      // Increment on each event, holding at all-ones instead of wrapping.
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (evt[gi] && (cnt_q[gi] != 32'hFFFF_FFFF)) cnt_d[gi] = cnt_q[gi] + 32'd1;
      end

      // Counter register, cleared by reset.
      always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q[gi] <= '0;
        else       cnt_q[gi] <= cnt_d[gi];
      end
    end
  endgenerate

  assign stat_push_o = cnt_q[0];
  assign stat_pop_o  = cnt_q[1];
  assign stat_ovf_o  = cnt_q[2];
  assign stat_udf_o  = cnt_q[3];

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: circular stack with wrap-on-overflow,
// suppressed underflow and a single checkpoint/restore for flush repair.
// Optional event counters are enabled by defining RAS_CTRL_STATS_EN.
// DEPTH must equal RAS_DEPTH since the checkpoint record is sized from it.
module ras_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [63:0] push_addr_i,
  input  logic        pop_i,
  input  logic        checkpoint_i,
  input  logic        restore_i,
  output logic [63:0] ra_o,
  output logic        ra_valid_o,
  output logic        overflow_o,
  output logic        underflow_o
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [31:0] stat_push_o,
  output logic [31:0] stat_pop_o,
  output logic [31:0] stat_ovf_o,
  output logic [31:0] stat_udf_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [63:0]      entries_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  ras_ckpt_t        ckpt_q, ckpt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [63:0]      wr_data;
  logic             acc_push, acc_pop;

  // Next-state: restore wins, otherwise push/pop arbitration, then checkpoint
  // captures the post-update state including a same-cycle write to the top.
  always_comb begin
    tos_d    = tos_q;
    cnt_d    = cnt_q;
    ckpt_d   = ckpt_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = tos_q;
    wr_data  = push_addr_i;
    acc_push = 1'b0;
    acc_pop  = 1'b0;
    if (restore_i) begin
      tos_d   = ckpt_q.tos;
      cnt_d   = ckpt_q.cnt;
      wr_en   = 1'b1;
      wr_idx  = ckpt_q.tos;
      wr_data = ckpt_q.top_value;
    end else begin
      if (push_i && pop_i && (cnt_q != '0)) begin
        // Replace the top in place: return consumed, new call pushed.
        wr_en    = 1'b1;
        acc_push = 1'b1;
        acc_pop  = 1'b1;
      end else if (push_i) begin
        tos_d    = tos_q + PTR_ONE;
        wr_en    = 1'b1;
        wr_idx   = tos_d;
        acc_push = 1'b1;
        if (cnt_q == CNT_FULL) ovf_d = 1'b1;
        else                   cnt_d = cnt_q + CNT_ONE;
      end else if (pop_i) begin
        if (cnt_q != '0) begin
          tos_d   = tos_q - PTR_ONE;
          cnt_d   = cnt_q - CNT_ONE;
          acc_pop = 1'b1;
        end else begin
          udf_d = 1'b1;
        end
      end
      if (checkpoint_i) begin
        ckpt_d.tos       = tos_d;
        ckpt_d.cnt       = cnt_d;
        ckpt_d.top_value = (wr_en && (wr_idx == tos_d)) ? wr_data : entries_q[tos_d];
      end
    end
  end

  // Pointer, count, checkpoint and event pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos_q  <= '0;
      cnt_q  <= '0;
      ckpt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      tos_q  <= tos_d;
      cnt_q  <= cnt_d;
      ckpt_q <= ckpt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // One stack slot; written only when it is the selected write target.
      always_ff @(posedge clk_i) begin
        if (rst_i)                                 entries_q[gi] <= '0;
        else if (wr_en && (wr_idx == PTR_W'(gi)))  entries_q[gi] <= wr_data;
      end
    end
  endgenerate

  assign ra_o        = entries_q[tos_q];
  assign ra_valid_o  = (cnt_q != '0);
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

`ifdef RAS_CTRL_STATS_EN
  ras_ctrl_stats u_stats (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_evt_i  (acc_push),
    .pop_evt_i   (acc_pop),
    .ovf_evt_i   (ovf_d),
    .udf_evt_i   (udf_d),
    .stat_push_o (stat_push_o),
    .stat_pop_o  (stat_pop_o),
    .stat_ovf_o  (stat_ovf_o),
    .stat_udf_o  (stat_udf_o)
  );
`else
  logic unused_acc;
  assign unused_acc = acc_push ^ acc_pop;
`endif

endmodule
